// File: rtl/psum_accumulator_if.sv
// -----------------------------------------------------------------------------
// psum_accumulator_if
// Bundles the two valid/ready streams around the partial-sum accumulator.
//
// Handshake rule, identical on both streams: a transfer happens on a rising clk
// edge where valid and ready are both high. The producer holds valid and its
// payload steady until that edge. The consumer may raise or drop ready at any
// time, and ready never depends combinationally on valid.
//
//   Input stream  (multiplier -> accumulator): in_valid / in_ready,
//                 payload in_psum, in_last, mode
//   Output stream (accumulator -> requant):    out_valid / out_ready,
//                 payload out_acc, out_mode, out_cnt, out_ovf
//
// Modports
//   master : environment side. Drives input beats and consumes results.
//   slave  : accumulator side.
// -----------------------------------------------------------------------------
interface psum_accumulator_if #(
  parameter int PSUM_W = 24,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 8
);
  logic              mode;
  logic              in_valid;
  logic              in_ready;
  logic [PSUM_W-1:0] in_psum;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic              out_mode;
  logic [CNT_W-1:0]  out_cnt;
  logic              out_ovf;

  modport master (
    output mode, in_valid, in_psum, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_mode, out_cnt, out_ovf
  );

  modport slave (
    input  mode, in_valid, in_psum, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_mode, out_cnt, out_ovf
  );
endinterface

// File: rtl/psum_accumulator.sv
// -----------------------------------------------------------------------------
// psum_accumulator
// Sums the stream of products from the 8b/2x4b multiplier. A group of beats
// ends with in_last, and each group produces one result. In 2x4b mode the
// product holds two packed halves {hi,lo}. Each half has its own lane sum, and
// no carry passes between the lanes.
//
// Ports
//   clk, rst   : clock; synchronous active-high reset
//   bus        : psum_accumulator_if.slave
//                (mode, in_valid/in_ready, in_psum, in_last,
//                 out_valid/out_ready, out_acc, out_mode, out_cnt, out_ovf)
//   dbg_state  : current FSM state (IDLE=0, ACC=1, HOLD=2)
//
// Build option
//   PSUM_ACC_SAT_EN : when defined, a lane that overflows clamps to its most
//                     positive or most negative value. When undefined, the
//                     lane wraps. out_ovf is set in both builds.
// -----------------------------------------------------------------------------
module psum_accumulator #(
  parameter int PSUM_W = 24,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  psum_accumulator_if.slave  bus,
  output logic [1:0]         dbg_state
);
  localparam int HW = ACC_W / 2;   // lane width in 2x4b mode
  localparam int PH = PSUM_W / 2;  // product half width

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

`ifdef PSUM_ACC_SAT_EN
  localparam logic [ACC_W-1:0] FULL_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] FULL_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [HW-1:0]    LANE_MAX = {1'b0, {(HW-1){1'b1}}};
  localparam logic [HW-1:0]    LANE_MIN = {1'b1, {(HW-1){1'b0}}};
`endif

  logic [1:0]       state;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             mode_q;

  logic             in_ready_int;
  logic             beat_fire;
  logic             op_mode;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] full_b, full_s;
  logic             full_o;
  logic [HW-1:0]    lo_b, lo_s, hi_b, hi_s;
  logic             lo_o, hi_o;
  logic [ACC_W-1:0] sum_next;
  logic             ovf_add;

  // Ready and valid are gated by rst. This keeps both low during the reset
  // cycle, whatever state the FSM is in.
  assign in_ready_int  = !rst && (state != S_HOLD);
  assign beat_fire     = bus.in_valid && in_ready_int;
  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = !rst && (state == S_HOLD);
  assign bus.out_acc   = acc_q;
  assign bus.out_mode  = mode_q;
  assign bus.out_cnt   = cnt_q;
  assign bus.out_ovf   = ovf_q;
  assign dbg_state     = state;

  // The first beat of a group adds onto zero. So the same adders also do the
  // load, and a first beat can never raise overflow.
  always_comb begin
    op_mode = (state == S_IDLE) ? bus.mode : mode_q;
    base    = (state == S_IDLE) ? '0 : acc_q;

    full_b = {{(ACC_W-PSUM_W){bus.in_psum[PSUM_W-1]}}, bus.in_psum};
    full_s = base + full_b;
    full_o = (base[ACC_W-1] == full_b[ACC_W-1]) && (full_s[ACC_W-1] != base[ACC_W-1]);

    lo_b = {{(HW-PH){bus.in_psum[PH-1]}}, bus.in_psum[PH-1:0]};
    lo_s = base[HW-1:0] + lo_b;
    lo_o = (base[HW-1] == lo_b[HW-1]) && (lo_s[HW-1] != base[HW-1]);

    hi_b = {{(HW-PH){bus.in_psum[PSUM_W-1]}}, bus.in_psum[PSUM_W-1:PH]};
    hi_s = base[ACC_W-1:HW] + hi_b;
    hi_o = (base[ACC_W-1] == hi_b[HW-1]) && (hi_s[HW-1] != base[ACC_W-1]);

`ifdef PSUM_ACC_SAT_EN
    // An overflow means both operands had the same sign. So the sign of the
    // old lane value tells which limit to clamp to.
    if (full_o) full_s = base[ACC_W-1] ? FULL_MIN : FULL_MAX;
    if (lo_o)   lo_s   = base[HW-1]    ? LANE_MIN : LANE_MAX;
    if (hi_o)   hi_s   = base[ACC_W-1] ? LANE_MIN : LANE_MAX;
`endif

    if (op_mode) begin
      sum_next = {hi_s, lo_s};
      ovf_add  = hi_o | lo_o;
    end else begin
      sum_next = full_s;
      ovf_add  = full_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      acc_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (beat_fire) begin
            mode_q <= bus.mode;
            acc_q  <= sum_next;
            cnt_q  <= CNT_W'(1);
            ovf_q  <= 1'b0;
            state  <= bus.in_last ? S_HOLD : S_ACC;
          end
        end
        S_ACC: begin
          if (beat_fire) begin
            acc_q <= sum_next;
            cnt_q <= cnt_q + CNT_W'(1);  // wraps silently on long groups
            ovf_q <= ovf_q | ovf_add;
            if (bus.in_last) state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
